mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Sits directly downstream of register_file: its operands come from reg_read_data_1/2.
//   Executes MULT, MULTU, DIV and DIVU in one bit per cycle, plus MTHI/MTLO writes.
//   Exposes HI/LO to the writeback mux for MFHI/MFLO. busy drives the core stall.
// PARAMETERS
//   WIDTH    32  operand/HI/LO width; iterations per op = WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset (0 = reset)
//   start    in   1      launch op; honoured only when busy=0
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    in   WIDTH  multiplicand / dividend (rs)
//   src_b    in   WIDTH  multiplier / divisor (rt)
//   hi_we    in   1      MTHI: HI <= wr_data
//   lo_we    in   1      MTLO: LO <= wr_data
//   wr_data  in   WIDTH  MTHI/MTLO data (rs)
//   busy     out  1      op in flight; core must stall MF*/MT*/new ops
//   done     out  1      one-cycle pulse: HI/LO now hold the result
//   hi       out  WIDTH  HI register (mult: upper product; div: remainder)
//   lo       out  WIDTH  LO register (mult: lower product; div: quotient)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; hi=lo=0; busy=0; done=0; counter=0.
//   FSM IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 at edge N: latch op and the signs of a/b.
//     Latch |a|, |b| for signed ops; raw values for unsigned.
//     Clear the accumulator. counter=0. Go to RUN. busy=1 from N.
//   RUN: edges N+1..N+WIDTH do one iteration each; counter increments.
//     Leave RUN after counter reaches WIDTH-1.
//     mul: shift-add. If multiplier bit=1, add the multiplicand. Shift the 2*WIDTH accumulator right.
//     div: restoring. Shift {rem,quo} left and trial-subtract the divisor.
//       Keep the result if non-negative and set the quotient bit.
//   FIX at edge N+WIDTH+1: apply the sign fix and write hi/lo.
//     done<=1 for exactly one cycle; busy<=0; go to IDLE.
//     Start-to-done latency: WIDTH+2 edges (34 for WIDTH=32).
//   Sign rules, signed ops only. All arithmetic is modulo 2^WIDTH / 2^(2*WIDTH).
//     MULT: negate the 64-bit product if sign_a^sign_b.
//     DIV: negate the quotient if sign_a^sign_b. Remainder takes the sign of a (truncating division).
//   Divide by zero: same latency; hi=src_a (unmodified); lo={WIDTH{1}}.
//   Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Falls out of the abs arithmetic.
//   hi/lo change only at FIX, on MT* writes, or at reset. They are stable during RUN.
//   Ignored while busy=1: start, hi_we and lo_we. No queuing.
//   IDLE with start=1 and hi_we/lo_we=1 in the same cycle:
//     The MT* write takes effect; the op starts; the op result later overwrites HI/LO.
//   hi_we and lo_we may both be 1; both registers take wr_data.
//   done and start in the same cycle: the new op is accepted (unit is IDLE by then).
//   Reset asserted mid-op: the op is aborted at once. No done pulse. Outputs go to reset values.
//   Operands are sampled only at the start edge. Later src_a/src_b changes have no effect.
// TESTING
//   MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+34; hi=0xFFFFFFFE lo=0x00000001.
//   MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
//   DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU a=100 b=7 -> lo=14 hi=2.
//     DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
//   DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234 at start+34; no hang.
//   Pulse start and hi_we at cycle 5 of a run -> both ignored.
//     MTLO 0xA5A5A5A5 when idle -> lo=0xA5A5A5A5 next edge.
//   Drive rst=0 at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately; no done pulse.
//     Afterwards a new op completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    launch op (honoured only when busy=0)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    multiplicand / dividend
//   src_b    multiplier / divisor
//   hi_we    MTHI write strobe (ignored while busy)
//   lo_we    MTLO write strobe (ignored while busy)
//   wr_data  MTHI/MTLO data
//   busy     op in flight
//   done     one-cycle pulse when HI/LO hold the result
//   hi, lo   HI/LO registers
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               busy_d, done_d;
  logic [WIDTH-1:0]   hi_d, lo_d;

  // Operand preparation at the start edge
  logic               is_signed;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Per-iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  // Sign-fixed results
  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand sign handling: signed ops work on magnitudes
  always_comb begin
    is_signed = ~op[0];
    sgn_a     = is_signed & src_a[WIDTH-1];
    sgn_b     = is_signed & src_b[WIDTH-1];
    abs_a     = sgn_a ? WIDTH'(-src_a) : src_a;
    abs_b     = sgn_b ? WIDTH'(-src_b) : src_b;
  end

  // One multiply / divide step and the final sign fix
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opnd_q};
    div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // Partial remainder stays below 2^WIDTH whenever the subtract is kept
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    prod_fix  = neg_res_q ? ACC_W'(-acc_q) : acc_q;
    quo_fix   = neg_res_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? WIDTH'(-acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    busy_d    = busy;
    done_d    = 1'b0;
    hi_d      = hi;
    lo_d      = lo;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start) begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          div0_d    = (src_b == '0);
          if (op[1]) begin
            // {rem, quo}: remainder cleared, dividend shifts in from the bottom
            opnd_d = abs_b;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
          end else begin
            // {product_hi, multiplier}: multiplier bits consumed from bit 0
            opnd_d = abs_a;
            acc_d  = {{WIDTH{1'b0}}, abs_b};
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          if (div_ge) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[ACC_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero leaves |a| in the remainder, so the sign fix restores a
          hi_d = rem_fix;
          lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy      <= busy_d;
      done      <= done_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table + scoreboard queue,
// plus hand-written sequences for MT* writes, ignored strobes and mid-op reset.
module tb_mult_div_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         hi_we, lo_we;
  logic [W-1:0] wr_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from native SystemVerilog arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    int     sa, sb_i;
    logic [63:0] u;
    sa   = $signed(a);
    sb_i = $signed(b);
    case (o)
      2'b00: begin p = longint'(sa) * longint'(sb_i); {e.hi, e.lo} = p; end
      2'b01: begin u = {32'h0, a} * {32'h0, b}; {e.hi, e.lo} = u; end
      2'b10: begin
        if (b == 0) begin e.hi = a; e.lo = '1; end
        else begin e.lo = sa / sb_i; e.hi = sa % sb_i; end
      end
      default: begin
        if (b == 0) begin e.hi = a; e.lo = '1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  // Launch an op: push expectation, pulse start, scramble operands afterwards
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Wait (bounded) for done; latency counted including the start edge
  task automatic finish_op(input string name, input int lat0);
    int   lat;
    exp_t e;
    lat = lat0;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    e = sb.pop_front();
    chk({name, "_hi"}, 64'(hi), 64'(e.hi));
    chk({name, "_lo"}, 64'(lo), 64'(e.lo));
    chk({name, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    launch(o, a, b, eh, el);
    finish_op(name, 1);
    step();
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] ra, rb, hold_hi, hold_lo;
    logic [1:0]   ro;
    int           pulses;

    tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[6]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    tbl[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[8]  = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    tbl[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    tbl[10] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    step(); step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    step();

    // Table vectors
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    // Random vectors against the native-arithmetic model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (rb == 0 || rb == 32'hFFFFFFFF) rb = 32'd3;
      e = model(ro, ra, rb);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, e.hi, e.lo);
    end

    // MTLO / MTHI while idle
    lo_we = 1'b1; wr_data = 32'hA5A5A5A5;
    step();
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hA5A5A5A5);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0BADF00D;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'h0BADF00D);
    chk("mt_both_lo", 64'(lo), 64'h0BADF00D);

    // start and MTLO together: write lands, op result then overwrites
    lo_we = 1'b1; wr_data = 32'h55;
    launch(2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
    lo_we = 1'b0;
    chk("mt_with_start_lo", 64'(lo), 64'h55);
    finish_op("mt_with_start", 1);

    // start / hi_we during a run are ignored; hi/lo stable in RUN
    step();
    hold_hi = hi;
    hold_lo = lo;
    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (4) step();
    start = 1'b1; op = 2'b01; src_a = 32'h11; src_b = 32'h22;
    hi_we = 1'b1; wr_data = 32'hDEADBEEF;
    step();
    start = 1'b0; hi_we = 1'b0;
    chk("run_hi_stable", 64'(hi), 64'(hold_hi));
    chk("run_lo_stable", 64'(lo), 64'(hold_lo));
    finish_op("ignored_strobes", 6);
    pulses = 0;
    repeat (40) begin step(); if (done || busy) pulses++; end
    chk("no_queued_op", 64'(pulses), 64'd0);

    // done and start in the same cycle: next op accepted immediately
    launch(2'b01, 32'd5, 32'd9, 32'd0, 32'd45);
    finish_op("b2b_first", 1);
    launch(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
    finish_op("b2b_second", 1);
    step();

    // Reset in the middle of a MULT
    e.hi = 0; e.lo = 0;
    op = 2'b00; src_a = 32'h1234; src_b = 32'h5678; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    pulses = 0;
    repeat (3) begin step(); if (done) pulses++; end
    rst = 1'b1;
    repeat (40) begin step(); if (done || busy) pulses++; end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op("after_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
